// File: rtl/sha3_block_padder_if.sv
// Padder message port plus block handoff to the Keccak core.
// The master drives message words and block acks; the slave is the padder itself.
interface sha3_block_padder_if #(
    parameter int RATE_WORDS = 18
);
    logic [31:0]              in;
    logic                     in_ready;
    logic                     is_last;
    logic [1:0]               byte_num;
    logic                     buffer_full;
    logic [32*RATE_WORDS-1:0] out;
    logic                     out_ready;
    logic                     last_block;
    logic                     f_ack;

    modport master (
        output in, in_ready, is_last, byte_num, f_ack,
        input  buffer_full, out, out_ready, last_block
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, f_ack,
        output buffer_full, out, out_ready, last_block
    );
endinterface

// File: rtl/sha3_block_padder.sv
// SHA-3 pad10*1 padder: packs 32-bit words into rate blocks; a block is ready the edge its last word lands.
// Backpressure: buffer_full holds off input during padding and until the core acks the full block.
module sha3_block_padder #(
    parameter logic [7:0] PAD_BYTE   = 8'h06,
    parameter int         RATE_WORDS = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    sha3_block_padder_if.slave   bus
);
    localparam int         BW       = 32 * RATE_WORDS;
    localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_PAD    = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [4:0]    word_cnt_q, word_cnt_d;
    logic [BW-1:0] buffer_q, buffer_d;
    logic          last_block_q, last_block_d;
    logic [31:0]   last_w;
    logic [31:0]   pad_w;
    logic          at_last_idx;

    assign at_last_idx = (word_cnt_q == LAST_IDX);

    // Final message word: keep byte_num leading bytes, append the domain byte, zero the rest.
    always_comb begin
        last_w = '0;
        case (bus.byte_num)
            2'd0:    last_w = {PAD_BYTE, 24'h0};
            2'd1:    last_w = {bus.in[31:24], PAD_BYTE, 16'h0};
            2'd2:    last_w = {bus.in[31:16], PAD_BYTE, 8'h0};
            default: last_w = {bus.in[31:8], PAD_BYTE};
        endcase
        if (at_last_idx) begin
            last_w[7:0] = last_w[7:0] | 8'h80;
        end
    end

    assign pad_w = at_last_idx ? 32'h0000_0080 : 32'h0;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        buffer_d     = buffer_q;
        last_block_d = last_block_q;
        case (state_q)
            ST_ACCEPT: begin
                if (bus.in_ready) begin
                    buffer_d = {buffer_q[BW-33:0], bus.is_last ? last_w : bus.in};
                    if (at_last_idx) begin
                        word_cnt_d   = '0;
                        state_d      = ST_FULL;
                        last_block_d = bus.is_last;
                    end else begin
                        word_cnt_d = word_cnt_q + 5'd1;
                        if (bus.is_last) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                buffer_d = {buffer_q[BW-33:0], pad_w};
                if (at_last_idx) begin
                    word_cnt_d   = '0;
                    state_d      = ST_FULL;
                    last_block_d = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 5'd1;
                end
            end
            ST_FULL: begin
                // Input arriving alongside the ack is dropped; the producer waits on buffer_full.
                if (bus.f_ack) begin
                    buffer_d     = '0;
                    word_cnt_d   = '0;
                    last_block_d = 1'b0;
                    state_d      = ST_ACCEPT;
                end
            end
            default: begin
                buffer_d     = '0;
                word_cnt_d   = '0;
                last_block_d = 1'b0;
                state_d      = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACCEPT;
            word_cnt_q   <= '0;
            buffer_q     <= '0;
            last_block_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            buffer_q     <= buffer_d;
            last_block_q <= last_block_d;
        end
    end

    assign bus.buffer_full = (state_q != ST_ACCEPT);
    assign bus.out_ready   = (state_q == ST_FULL);
    assign bus.out         = buffer_q;
    assign bus.last_block  = last_block_q;
endmodule

// File: tb/tb_sha3_block_padder.sv
// Directed bench for sha3_block_padder: reset, padding cases, block boundary, multi-block.
module tb_sha3_block_padder;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sha3_block_padder_if #(.RATE_WORDS(18)) bus ();

    sha3_block_padder #(.PAD_BYTE(8'h06), .RATE_WORDS(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] bn);
        bus.in       = d;
        bus.in_ready = 1'b1;
        bus.is_last  = last;
        bus.byte_num = bn;
        tick();
        bus.in_ready = 1'b0;
        bus.is_last  = 1'b0;
        bus.byte_num = 2'd0;
    endtask

    task automatic ack();
        bus.f_ack = 1'b1;
        tick();
        bus.f_ack = 1'b0;
    endtask

    task automatic wait_full(input string tag);
        int n = 0;
        while (!bus.out_ready && n < 40) begin
            tick();
            n++;
        end
        check(tag, 576'(bus.out_ready), 576'(1));
    endtask

    logic [575:0] exp_blk;

    initial begin
        reset        = 1'b1;
        bus.in       = 32'hFFFF_FFFF;
        bus.in_ready = 1'b1;
        bus.is_last  = 1'b0;
        bus.byte_num = 2'd0;
        bus.f_ack    = 1'b0;

        // 1. reset with input active
        tick();
        tick();
        check("rst_out", bus.out, '0);
        check("rst_out_ready", 576'(bus.out_ready), '0);
        check("rst_buffer_full", 576'(bus.buffer_full), '0);
        check("rst_last_block", 576'(bus.last_block), '0);
        bus.in_ready = 1'b0;
        reset = 1'b0;
        tick();

        // reset in the middle of padding
        send(32'h1234_5678, 1'b0, 2'd0);
        send(32'h0, 1'b1, 2'd0);
        tick();
        tick();
        check("midpad_busy", 576'(bus.buffer_full), 576'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midpad_rst_out", bus.out, '0);
        check("midpad_rst_full", 576'(bus.buffer_full), '0);
        check("midpad_rst_ready", 576'(bus.out_ready), '0);

        // 2. empty message: ready exactly 17 edges after the final word
        send(32'h0, 1'b1, 2'd0);
        check("empty_bf", 576'(bus.buffer_full), 576'(1));
        for (int i = 0; i < 16; i++) tick();
        check("empty_not_yet", 576'(bus.out_ready), '0);
        tick();
        check("empty_ready", 576'(bus.out_ready), 576'(1));
        exp_blk = {32'h0600_0000, 512'h0, 32'h0000_0080};
        check("empty_block", bus.out, exp_blk);
        check("empty_last", 576'(bus.last_block), 576'(1));
        ack();
        check("empty_ack_bf", 576'(bus.buffer_full), '0);
        check("empty_ack_out", bus.out, '0);

        // 3. "abc"
        send(32'h6162_6300, 1'b1, 2'd3);
        wait_full("abc_timeout");
        exp_blk = {32'h6162_6306, 512'h0, 32'h0000_0080};
        check("abc_block", bus.out, exp_blk);
        check("abc_last", 576'(bus.last_block), 576'(1));
        ack();

        // 4. exactly one full block of data
        exp_blk = '0;
        for (int i = 0; i < 18; i++) begin
            check("full_not_ready", 576'(bus.out_ready), '0);
            send(32'(i), 1'b0, 2'd0);
            exp_blk[575-32*i -: 32] = 32'(i);
        end
        check("full_ready", 576'(bus.out_ready), 576'(1));
        check("full_last", 576'(bus.last_block), '0);
        check("full_block", bus.out, exp_blk);
        send(32'hDEAD_BEEF, 1'b0, 2'd0);
        check("full_drop_in", bus.out, exp_blk);
        check("full_still_ready", 576'(bus.out_ready), 576'(1));
        bus.in       = 32'hBEEF_0001;
        bus.in_ready = 1'b1;
        ack();
        bus.in_ready = 1'b0;
        check("full_ack_bf", 576'(bus.buffer_full), '0);
        check("full_ack_out", bus.out, '0);
        check("full_ack_ready", 576'(bus.out_ready), '0);

        // 5. final word lands in the last slot
        exp_blk = '0;
        for (int i = 0; i < 17; i++) begin
            send(32'(i + 1), 1'b0, 2'd0);
            exp_blk[575-32*i -: 32] = 32'(i + 1);
        end
        send(32'h0, 1'b1, 2'd0);
        exp_blk[31:0] = 32'h0600_0080;
        check("bnd0_ready", 576'(bus.out_ready), 576'(1));
        check("bnd0_block", bus.out, exp_blk);
        check("bnd0_last", 576'(bus.last_block), 576'(1));
        ack();
        for (int i = 0; i < 17; i++) send(32'(i + 1), 1'b0, 2'd0);
        send(32'hAABB_CC00, 1'b1, 2'd3);
        exp_blk[31:0] = 32'hAABB_CC86;
        check("bnd3_ready", 576'(bus.out_ready), 576'(1));
        check("bnd3_block", bus.out, exp_blk);
        ack();

        // 6. message spanning two blocks
        exp_blk = '0;
        for (int i = 0; i < 18; i++) begin
            send(32'h100 + 32'(i), 1'b0, 2'd0);
            exp_blk[575-32*i -: 32] = 32'h100 + 32'(i);
        end
        check("multi_b0_block", bus.out, exp_blk);
        check("multi_b0_last", 576'(bus.last_block), '0);
        ack();
        send(32'h112, 1'b0, 2'd0);
        send(32'h113, 1'b0, 2'd0);
        send(32'h1100_0000, 1'b1, 2'd1);
        wait_full("multi_timeout");
        exp_blk = {32'h112, 32'h113, 32'h1106_0000, 448'h0, 32'h0000_0080};
        check("multi_b1_block", bus.out, exp_blk);
        check("multi_b1_last", 576'(bus.last_block), 576'(1));
        ack();
        check("multi_ack_ready", 576'(bus.out_ready), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sha3_block_padder.md
Name: sha3_block_padder

Overview:
Message padder between the crypto peripheral's SHA register interface and the Keccak-f[1600] permutation core.
- Accepts 32-bit message words from the peripheral register bank.
- Packs them into 576-bit rate blocks (SHA3-512, 18 words).
- Applies SHA-3 pad10*1 after the final word.
- Hands each full block to the permutation core with a ready/ack handshake.

Parameters:
PAD_BYTE, 8'h06, first padding byte (domain separator); 8'h01 selects original Keccak padding.
RATE_WORDS, 18, 32-bit words per block (576-bit rate).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
in  input  32  message word; byte order in[31:24] first.
in_ready  input  1  in is valid this cycle.
is_last  input  1  qualifies in_ready: this is the final, partial word.
byte_num  input  2  valid bytes in a last word (0..3), left-justified from in[31:24]. Ignored when is_last=0.
buffer_full  output  1  padder cannot accept input.
out  output  576  block; out[575:544] = first word of block.
out_ready  output  1  out holds a complete block.
last_block  output  1  block contains the end of message; valid while out_ready=1.
f_ack  input  1  consumer has taken the block.

Behaviour:
- Reset (synchronous, high at posedge):
  - State=ACCEPT; word_cnt=0; buffer=0.
  - out=0, out_ready=0, buffer_full=0, last_block=0.
  - Applies from any state, including mid-PAD or FULL; any partial block is discarded.
- States: ACCEPT, PAD, FULL.
- Outputs:
  - buffer_full = (state != ACCEPT).
  - out_ready = (state == FULL).
  - out = buffer register, always driven.
- ACCEPT, in_ready=1, is_last=0:
  - buffer <= {buffer[543:0], in}; word_cnt++.
  - If word_cnt was RATE_WORDS-1: state -> FULL, last_block=0.
- ACCEPT, in_ready=1, is_last=1: build word w.
  - Keep byte_num bytes of in from MSB.
  - Next byte = PAD_BYTE; remaining bytes 0.
  - byte_num=3 means bytes 0-2 are data and byte 3 = PAD_BYTE.
  - If w is word RATE_WORDS-1, OR 8'h80 into w[7:0]; for example, byte_num=3 gives low byte 8'h86.
  - Shift w in and increment word_cnt.
  - If the block is now full: FULL with last_block=1. Otherwise: PAD.
  - A final word always has at least one free byte, so padding never spills into an extra block.
  - A message that is a multiple of 4 bytes ends with an is_last word with byte_num=0.
- PAD: one word per cycle, no input sampled.
  - Shift in 32'h00000000, or 32'h00000080 for word RATE_WORDS-1.
  - On the final word: state -> FULL, last_block=1.
- FULL:
  - in_ready ignored; the word is dropped and there is no state change. The producer must wait for buffer_full=0.
  - f_ack=1: buffer <= 0, word_cnt <= 0, last_block <= 0, state -> ACCEPT. out_ready and buffer_full are low the next cycle.
  - in_ready in the same cycle as f_ack is dropped.
- f_ack outside FULL is ignored.
- Latency:
  - 18th data word accepted at edge t: out_ready=1 after t.
  - Last word accepted as word index k (0-based) at edge t: PAD writes words k+1..17 at edges t+1..t+17-k. out_ready=1 after edge t+17-k; for k=17, after t.
- word_cnt: 5 bits, range 0..RATE_WORDS-1 while accepting; never wraps without passing through FULL.

Test Plan:
1. Reset: hold reset 2 cycles with in_ready=1 -> out=0, out_ready=0, buffer_full=0, last_block=0. Repeat with reset asserted mid-PAD -> same values next cycle; no stale words appear in the following block.
2. Empty message: is_last=1, byte_num=0 at edge t -> buffer_full=1 after t; out_ready=1 after t+17. Block: word0=32'h06000000, words1-16=0, word17=32'h00000080; last_block=1.
3. "abc": in=32'h61626300, is_last=1, byte_num=3 -> word0=32'h61626306, word17=32'h00000080, all others 0, last_block=1.
4. Full block: 18 words 0..17, no is_last -> out_ready=1 and last_block=0 after the 18th edge; out[575:544]=0, out[31:0]=17. in_ready while FULL -> block unchanged. f_ack -> buffer_full=0 and out=0 the next cycle.
5. Boundary: 17 data words, then is_last with byte_num=0 -> word17=32'h06000080, out_ready the next cycle. Repeat with byte_num=3, in=32'hAABBCC00 -> word17=32'hAABBCC86.
6. Multi-block: 20 words, then is_last with byte_num=1, in=32'h11000000 -> first block last_block=0; ack; second block word2=32'h11060000, word17=32'h00000080, last_block=1.
